// File: rtl/sync_fifo_flagged.sv
// ---------------------------------------------------------------------------
// sync_fifo_flagged
//
// Single-clock FIFO with occupancy count, programmable almost-full and
// almost-empty flags, selectable read mode (registered or
// first-word-fall-through), and sticky overflow/underflow error flags that
// software can clear.
//
// Ports
//   clock              sole clock, rising edge
//   reset              synchronous, active-high; dominates all other inputs
//   write_data         word to push
//   write_enable       push request
//   write_full         fill_count == DEPTH
//   write_almost_full  fill_count >= ALMOST_FULL_LEVEL
//   read_enable        pop request (registered mode) / head acknowledge (FWFT)
//   read_data          popped word (registered mode) / head word (FWFT)
//   read_valid         read_data carries a valid word
//   read_empty         fill_count == 0
//   read_almost_empty  fill_count <= ALMOST_EMPTY_LEVEL
//   fill_count         words stored and not yet popped
//   overflow           sticky: write attempted while full
//   underflow          sticky: read attempted while empty
//   clear_errors       clears overflow/underflow
// ---------------------------------------------------------------------------
module sync_fifo_flagged #(
  parameter int DATA_WIDTH         = 8,
  parameter int ADDR_WIDTH         = 4,
  parameter int FWFT               = 0,
  parameter int ALMOST_FULL_LEVEL  = 14,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_enable,
  output logic                  write_full,
  output logic                  write_almost_full,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  read_empty,
  output logic                  read_almost_empty,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clear_errors
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LVL    = (ADDR_WIDTH + 1)'(ALMOST_FULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_LVL    = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_LEVEL);

  // Occupancy update. Acceptance is already gated by the full/empty flags,
  // so the count cannot leave 0..DEPTH; the clamp keeps that true even if
  // the gating were ever loosened.
  function automatic logic [ADDR_WIDTH:0] next_count(
    input logic [ADDR_WIDTH:0] cur,
    input logic                inc,
    input logic                dec
  );
    logic [ADDR_WIDTH:0] res;
    res = cur;
    if (inc && !dec && (cur != DEPTH_CNT)) begin
      res = cur + 1'b1;
    end else if (dec && !inc && (cur != '0)) begin
      res = cur - 1'b1;
    end
    return res;
  endfunction

  // Sticky error flag: a new event in the same cycle as a clear wins.
  function automatic logic sticky_next(
    input logic cur,
    input logic set,
    input logic clr
  );
    return set | (cur & ~clr);
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_p1;
  logic                  full_p1;
  logic                  afull_p1;
  logic                  empty_p1;
  logic                  aempty_p1;
  logic                  ovf_p1;
  logic                  unf_p1;

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  wr_err;
  logic                  rd_err;
  logic [ADDR_WIDTH:0]   count_nxt;

  always_comb begin
    wr_acc    = write_enable && !full_p1;
    rd_acc    = read_enable  && !empty_p1;
    wr_err    = write_enable &&  full_p1;
    rd_err    = read_enable  &&  empty_p1;
    count_nxt = next_count(count_p1, wr_acc, rd_acc);
  end

  // ---- stage p1: storage, pointers, count and flags ----
  always_ff @(posedge clock) begin
    if (wr_acc && !reset) begin
      mem[wr_ptr] <= write_data;
    end
  end

  // Flags are computed from the next-state count so they line up with
  // fill_count in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_p1  <= '0;
      full_p1   <= 1'b0;
      afull_p1  <= 1'b0;
      empty_p1  <= 1'b1;
      aempty_p1 <= 1'b1;
      ovf_p1    <= 1'b0;
      unf_p1    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_p1  <= count_nxt;
      full_p1   <= (count_nxt == DEPTH_CNT);
      afull_p1  <= (count_nxt >= AF_LVL);
      empty_p1  <= (count_nxt == '0);
      aempty_p1 <= (count_nxt <= AE_LVL);
      ovf_p1    <= sticky_next(ovf_p1, wr_err, clear_errors);
      unf_p1    <= sticky_next(unf_p1, rd_err, clear_errors);
    end
  end

  assign write_full        = full_p1;
  assign write_almost_full = afull_p1;
  assign read_empty        = empty_p1;
  assign read_almost_empty = aempty_p1;
  assign fill_count        = count_p1;
  assign overflow          = ovf_p1;
  assign underflow         = unf_p1;

  // ---- stage p2: read port ----
  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented straight from the array at the registered
      // read pointer; forced to zero while empty so the port is quiet.
      assign read_valid = !empty_p1;
      assign read_data  = empty_p1 ? '0 : mem[rd_ptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_p2;
      logic                  vld_p2;

      always_ff @(posedge clock) begin
        if (reset) begin
          rd_data_p2 <= '0;
          vld_p2     <= 1'b0;
        end else begin
          vld_p2 <= rd_acc;
          if (rd_acc) begin
            rd_data_p2 <= mem[rd_ptr];
          end
        end
      end

      assign read_valid = vld_p2;
      assign read_data  = rd_data_p2;
    end
  endgenerate

endmodule
